inst_fetch_buffer: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the dual-issue CPU core.
- Takes the core's word-granular instruction address (inst_addr) and returns the 32-bit instruction word (two 16-bit instructions) plus a stall flag.
- Hides a variable-latency instruction memory behind a 2-entry tagged line buffer with sequential next-word prefetch.
- Presents synchronous-ROM timing to the core: the word for the address sampled at edge N is on inst after edge N, or stall is held high until it is.

---
 rtl/inst_fetch_buffer_if.sv | 24 ++
 rtl/inst_fetch_buffer.sv | 142 ++++++++++++++
 tb/tb_inst_fetch_buffer.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_buffer_if.sv
// Instruction-memory request/response bus for the fetch buffer.
// master: fetch side (mem_req, mem_addr out); slave: memory side.
interface inst_fetch_buffer_if #(
  parameter int AW = 11
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Fetch stage: 2-entry tagged word buffer with next-word prefetch that
// gives the core sync-ROM timing over a variable-latency memory.
// Ports: clk, reset (sync, high); inst_addr in; inst/stall out;
// miss_count out (saturating); mem: memory bus (master modport).
module inst_fetch_buffer #(
  parameter int PC_WIDTH   = 12,
  parameter int MISS_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PC_WIDTH-2:0]   inst_addr,
  output logic [31:0]           inst,
  output logic                  stall,
  output logic [MISS_CNT_W-1:0] miss_count,
  inst_fetch_buffer_if.master   mem
);
  localparam int AW = PC_WIDTH - 1;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] tag;
    logic [31:0]   data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    DEMAND,
    PREFETCH,
    DRAIN
  } state_t;

  state_t          state;
  entry_t [1:0]    ent;
  logic [AW-1:0]   cur_addr;
  logic [AW-1:0]   req_addr;
  logic [AW-1:0]   nxt_addr;
  logic            req_q;
  logic            last_fill;
  logic            hit0;
  logic            hit1;
  logic            hit;
  logic            nxt_hit;
  logic            fill;
  logic            vic;

  assign nxt_addr = cur_addr + AW'(1);

  assign hit0 = ent[0].valid && (ent[0].tag == cur_addr);
  assign hit1 = ent[1].valid && (ent[1].tag == cur_addr);
  assign hit  = hit0 | hit1;

  assign nxt_hit = (ent[0].valid && (ent[0].tag == nxt_addr)) ||
                   (ent[1].valid && (ent[1].tag == nxt_addr));

  // Acks only count while something is outstanding.
  assign fill = (state != IDLE) && mem.mem_ack;

  assign stall = ~hit;

  // Tags never repeat across entries, so at most one hit is live.
  always_comb begin
    inst = '0;
    unique case (1'b1)
      hit0:    inst = ent[0].data;
      hit1:    inst = ent[1].data;
      default: inst = '0;
    endcase
  end

  // Keep the word the core is sitting on; alternate when neither is.
  always_comb begin
    vic = 1'b0;
    if (!ent[0].valid)
      vic = 1'b0;
    else if (!ent[1].valid)
      vic = 1'b1;
    else if (ent[0].tag == cur_addr)
      vic = 1'b1;
    else if (ent[1].tag == cur_addr)
      vic = 1'b0;
    else
      vic = ~last_fill;
  end

  assign mem.mem_req  = req_q & ~reset;
  assign mem.mem_addr = req_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cur_addr     <= '0;
      req_addr     <= '0;
      req_q        <= 1'b0;
      last_fill    <= 1'b0;
      miss_count   <= '0;
      ent[0].valid <= 1'b0;
      ent[1].valid <= 1'b0;
    end else begin
      cur_addr <= inst_addr;
      req_q    <= 1'b0;

      if (fill) begin
        ent[vic]  <= '{valid: 1'b1,
                       tag:   req_addr,
                       data:  mem.mem_rdata};
        last_fill <= vic;
      end

      unique case (state)
        IDLE: begin
          if (!hit) begin
            req_q    <= 1'b1;
            req_addr <= cur_addr;
            state    <= DEMAND;
            if (miss_count != '1)
              miss_count <= miss_count + MISS_CNT_W'(1);
          end else if (!nxt_hit) begin
            req_q    <= 1'b1;
            req_addr <= nxt_addr;
            state    <= PREFETCH;
          end
        end
        DEMAND: begin
          if (mem.mem_ack)
            state <= IDLE;
        end
        PREFETCH: begin
          // A miss on the prefetch target is served by this fill.
          if (mem.mem_ack)
            state <= IDLE;
          else if (!hit && (cur_addr != req_addr))
            state <= DRAIN;
        end
        DRAIN: begin
          if (mem.mem_ack)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: directed scenarios plus
// random core/memory traffic against a queue-free behavioural model.
module tb_inst_fetch_buffer;
  localparam int PCW = 12;
  localparam int AW  = PCW - 1;
  localparam int MW  = 4;

  logic          clk;
  logic          reset;
  logic [AW-1:0] inst_addr;
  logic [31:0]   inst;
  logic          stall;
  logic [MW-1:0] miss_count;

  inst_fetch_buffer_if #(.AW(AW)) mem_if ();

  inst_fetch_buffer #(
    .PC_WIDTH  (PCW),
    .MISS_CNT_W(MW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .inst_addr (inst_addr),
    .inst      (inst),
    .stall     (stall),
    .miss_count(miss_count),
    .mem       (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // observed outputs of the current cycle
  logic          o_stall;
  logic          o_req;
  logic [AW-1:0] o_addr;
  logic [31:0]   o_inst;
  logic [MW-1:0] o_cnt;

  // expected outputs of the current cycle
  logic          e_stall;
  logic          e_req;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_inst;
  logic [MW-1:0] e_cnt;

  // reference model state
  logic          md_v [2];
  logic [AW-1:0] md_t [2];
  logic [31:0]   md_d [2];
  logic [AW-1:0] md_cur;
  logic [AW-1:0] md_pend;
  logic          md_out;
  int            md_last;
  logic [MW-1:0] md_miss;

  // memory model
  logic          mem_busy;
  int            mem_left;
  logic [AW-1:0] mem_tgt;
  int            lat;
  logic          rnd_lat;

  function automatic logic [31:0] word(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_3C3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic int find(input logic [AW-1:0] a);
    for (int i = 0; i < 2; i++)
      if (md_v[i] && md_t[i] == a)
        return i;
    return -1;
  endfunction

  // One clock edge of the reference: at most one request in flight,
  // demand when the current word is absent, else prefetch the next.
  task automatic model(input logic rst, input logic [AW-1:0] addr,
                       input logic ack, input logic [31:0] rd);
    int vi;
    int k;
    logic [AW-1:0] nx;
    if (rst) begin
      md_v[0] = 1'b0;
      md_v[1] = 1'b0;
      md_cur  = '0;
      md_pend = '0;
      md_out  = 1'b0;
      md_last = 0;
      md_miss = '0;
      e_req   = 1'b0;
    end else begin
      e_req = 1'b0;
      nx = md_cur + 1'b1;
      if (md_out && ack) begin
        if (!md_v[0]) vi = 0;
        else if (!md_v[1]) vi = 1;
        else if (md_t[0] == md_cur) vi = 1;
        else if (md_t[1] == md_cur) vi = 0;
        else vi = (md_last == 0) ? 1 : 0;
        md_v[vi] = 1'b1;
        md_t[vi] = md_pend;
        md_d[vi] = rd;
        md_last  = vi;
        md_out   = 1'b0;
      end else if (!md_out) begin
        if (find(md_cur) < 0) begin
          e_req   = 1'b1;
          md_pend = md_cur;
          md_out  = 1'b1;
          if (md_miss != '1)
            md_miss = md_miss + 1'b1;
        end else if (find(nx) < 0) begin
          e_req   = 1'b1;
          md_pend = nx;
          md_out  = 1'b1;
        end
      end
      md_cur = addr;
    end
    e_addr  = md_pend;
    e_cnt   = md_miss;
    k       = find(md_cur);
    e_stall = (k < 0);
    e_inst  = (k < 0) ? 32'h0 : md_d[k];
  endtask

  task automatic obs();
    @(negedge clk);
    o_stall = stall;
    o_req   = mem_if.mem_req;
    o_addr  = mem_if.mem_addr;
    o_inst  = inst;
    o_cnt   = miss_count;
    chk("stall", 32'(o_stall), 32'(e_stall));
    chk("inst", o_inst, e_inst);
    chk("mem_req", 32'(o_req), 32'(e_req));
    if (e_req)
      chk("mem_addr", 32'(o_addr), 32'(e_addr));
    chk("miss_count", 32'(o_cnt), 32'(e_cnt));
  endtask

  task automatic drv(input logic rst, input logic [AW-1:0] addr);
    logic        ack;
    logic [31:0] rd;
    ack = 1'b0;
    rd  = '0;
    if (o_req)
      chk("req_while_busy", 32'(mem_busy), 32'd0);
    if (mem_busy) begin
      mem_left--;
      if (mem_left <= 0) begin
        ack      = 1'b1;
        rd       = word(mem_tgt);
        mem_busy = 1'b0;
      end
    end else if (!o_req && $urandom_range(0, 7) == 0) begin
      ack = 1'b1;
      rd  = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
    end
    if (o_req) begin
      mem_busy = 1'b1;
      mem_left = rnd_lat ? int'($urandom_range(1, 4)) : lat;
      mem_tgt  = o_addr;
    end
    // A request killed by reset still gets its (ignored) ack next cycle.
    if (rst && mem_busy)
      mem_left = 1;
    reset            = rst;
    inst_addr        = addr;
    mem_if.mem_ack   = ack;
    mem_if.mem_rdata = rd;
    model(rst, addr, ack, rd);
  endtask

  task automatic hold(input logic [AW-1:0] addr, input string tag);
    for (int i = 0; i < 60; i++) begin
      drv(1'b0, addr);
      obs();
      if (!o_stall)
        break;
    end
    chk(tag, 32'(o_stall), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int m0;
    logic [AW-1:0] a;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic done;
    logic rst;
    int r;

    reset            = 1'b1;
    inst_addr        = '0;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;
    mem_busy         = 1'b0;
    mem_left         = 0;
    mem_tgt          = '0;
    lat              = 3;
    rnd_lat          = 1'b0;
    model(1'b1, '0, 1'b0, '0);
    @(posedge clk);
    obs();
    drv(1'b1, '0);
    obs();

    // cold start, latency 3
    n = int'(o_stall);
    for (int i = 0; i < 20; i++) begin
      drv(1'b0, '0);
      obs();
      if (!o_stall)
        break;
      n++;
    end
    chk("cold_stall_cycles", 32'(n), 32'd5);
    chk("cold_inst", o_inst, word('0));
    chk("cold_miss", 32'(o_cnt), 32'd1);
    drv(1'b0, '0);
    obs();
    chk("cold_pf_req", 32'(o_req), 32'd1);
    chk("cold_pf_addr", 32'(o_addr), 32'd1);

    // sequential run 0..10, latency 1
    lat  = 1;
    a    = '0;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!o_stall && a == AW'(10)) begin
        done = 1'b1;
        break;
      end
      if (!o_stall)
        a = a + 1'b1;
      drv(1'b0, a);
      obs();
    end
    chk("seq_done", 32'(done), 32'd1);
    chk("seq_miss", 32'(o_cnt), 32'd1);

    // jump away while prefetch of 6 is in flight
    lat = 4;
    hold(AW'(5), "jump_hit5");
    m0  = int'(o_cnt);
    n   = 0;
    ra0 = '1;
    ra1 = '1;
    for (int i = 0; i < 60; i++) begin
      drv(1'b0, AW'('h40));
      obs();
      if (o_req) begin
        if (n == 0) ra0 = o_addr;
        if (n == 1) ra1 = o_addr;
        n++;
      end
      if (!o_stall)
        break;
    end
    chk("jump_stall", 32'(o_stall), 32'd0);
    chk("jump_nreq", 32'(n), 32'd2);
    chk("jump_req0", 32'(ra0), 32'd6);
    chk("jump_req1", 32'(ra1), 32'h40);
    chk("jump_miss", 32'(o_cnt), 32'(m0 + 1));
    chk("jump_inst", o_inst, word(AW'('h40)));

    // jump onto the prefetch target
    lat = 3;
    hold(AW'(20), "tgt_hit20");
    m0  = int'(o_cnt);
    n   = 0;
    ra0 = '1;
    for (int i = 0; i < 60; i++) begin
      drv(1'b0, AW'(21));
      obs();
      if (o_req) begin
        if (n == 0) ra0 = o_addr;
        n++;
      end
      if (!o_stall)
        break;
    end
    chk("tgt_stall", 32'(o_stall), 32'd0);
    chk("tgt_nreq", 32'(n), 32'd1);
    chk("tgt_req0", 32'(ra0), 32'd21);
    chk("tgt_miss", 32'(o_cnt), 32'(m0));

    // prefetch wraps from the top word to 0
    lat = 2;
    hold('1, "wrap_hit");
    drv(1'b0, '1);
    obs();
    chk("wrap_req", 32'(o_req), 32'd1);
    chk("wrap_addr", 32'(o_addr), 32'd0);

    // reset while a demand is outstanding
    lat = 4;
    for (int i = 0; i < 30; i++) begin
      drv(1'b0, AW'(100));
      obs();
      if (o_req && o_addr == AW'(100))
        break;
    end
    chk("rd_req", 32'(o_addr), 32'd100);
    drv(1'b1, '0);
    obs();
    drv(1'b0, '0);
    obs();
    chk("rd_new_req", 32'(o_req), 32'd1);
    chk("rd_new_addr", 32'(o_addr), 32'd0);
    chk("rd_miss", 32'(o_cnt), 32'd1);
    hold('0, "rd_hit");
    chk("rd_inst", o_inst, word('0));

    // random traffic
    rnd_lat = 1'b1;
    a = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!o_stall) begin
        r = int'($urandom_range(0, 99));
        if (r < 60)
          a = a + 1'b1;
        else if (r < 85)
          a = AW'($urandom_range(0, 31));
        else if (r < 95)
          a = AW'($urandom);
      end
      rst = ($urandom_range(0, 299) == 0);
      drv(rst, a);
      obs();
    end

    // saturation: 20 forced misses
    rnd_lat = 1'b0;
    lat = 2;
    for (int k = 0; k < 20; k++)
      hold(AW'(300 + 5 * k), "sat_hit");
    chk("sat_count", 32'(o_cnt), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
